// File: rtl/axistream_width_downsizer.sv
// AXI-Stream width downsizer: serializes RATIO-lane input beats into single
// OUT_WIDTH lanes, lane 0 first, trimming trailing lanes per tkeep.
module axistream_width_downsizer #(
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned RATIO     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       src_tvalid,
    output logic                       src_tready,
    input  logic [OUT_WIDTH*RATIO-1:0] src_tdata,
    input  logic [RATIO-1:0]           src_tkeep,
    input  logic                       src_tlast,
    output logic                       dest_tvalid,
    input  logic                       dest_tready,
    output logic [OUT_WIDTH-1:0]       dest_tdata,
    output logic                       dest_tlast,
    output logic                       busy
);

    localparam int unsigned IN_WIDTH = OUT_WIDTH * RATIO;
    localparam int unsigned IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IN_WIDTH-1:0]  data_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     last_idx_q;
    logic                 tlast_q;
    logic                 rdy_en_q;

    logic                 load_c;
    logic                 advance_c;
    logic                 final_lane_c;
    logic [RATIO-1:0]     keep_eff_c;
    logic [IDX_W-1:0]     cap_last_idx_c;
    logic [OUT_WIDTH-1:0] lane_c;

    // Last lane to emit: highest set keep bit, with lane 0 always present.
    always_comb begin
        keep_eff_c     = src_tkeep | RATIO'(1);
        cap_last_idx_c = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (keep_eff_c[i]) begin
                cap_last_idx_c = IDX_W'(i);
            end
        end
    end

    always_comb begin
        lane_c = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (idx_q == IDX_W'(i)) begin
                lane_c = data_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign final_lane_c = (idx_q == last_idx_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a final-lane handshake may reload in the same cycle.
    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        advance_c = 1'b0;
        case (state_q)
            EMPTY: begin
                if (src_tvalid && rdy_en_q) begin
                    load_c  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (dest_tready) begin
                    if (final_lane_c) begin
                        if (src_tvalid) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else begin
                        advance_c = 1'b1;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        src_tready  = 1'b0;
        dest_tvalid = 1'b0;
        dest_tdata  = '0;
        dest_tlast  = 1'b0;
        busy        = 1'b0;
        case (state_q)
            EMPTY: begin
                src_tready = rdy_en_q;
            end
            SHIFT: begin
                dest_tvalid = 1'b1;
                busy        = 1'b1;
                dest_tdata  = lane_c;
                dest_tlast  = tlast_q && final_lane_c;
                src_tready  = final_lane_c && dest_tready;
            end
            default: ;
        endcase
    end

    // Holding register and lane index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            tlast_q    <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (load_c) begin
                data_q     <= src_tdata;
                idx_q      <= '0;
                last_idx_q <= cap_last_idx_c;
                tlast_q    <= src_tlast;
            end else if (advance_c) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axistream_width_downsizer.sv
// Directed bench for axistream_width_downsizer: inputs change on the falling
// edge, outputs are checked 1 ns later against hand-computed values.
module tb_axistream_width_downsizer;

    logic        clk;
    logic        rst;
    logic        src_tvalid;
    logic        src_tready;
    logic [31:0] src_tdata;
    logic [3:0]  src_tkeep;
    logic        src_tlast;
    logic        dest_tvalid;
    logic        dest_tready;
    logic [7:0]  dest_tdata;
    logic        dest_tlast;
    logic        busy;

    int total = 0;
    int bad   = 0;

    axistream_width_downsizer #(.OUT_WIDTH(8), .RATIO(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_tvalid  (src_tvalid),
        .src_tready  (src_tready),
        .src_tdata   (src_tdata),
        .src_tkeep   (src_tkeep),
        .src_tlast   (src_tlast),
        .dest_tvalid (dest_tvalid),
        .dest_tready (dest_tready),
        .dest_tdata  (dest_tdata),
        .dest_tlast  (dest_tlast),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (inputs applied by the caller afterwards).
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic exp_lane(input string tag, input logic [7:0] d, input logic l, input logic srdy);
        chk({tag, "_valid"}, 32'(dest_tvalid), 32'd1);
        chk({tag, "_data"},  32'(dest_tdata),  32'(d));
        chk({tag, "_last"},  32'(dest_tlast),  32'(l));
        chk({tag, "_srdy"},  32'(src_tready),  32'(srdy));
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_valid"}, 32'(dest_tvalid), 32'd0);
        chk({tag, "_srdy"},  32'(src_tready),  32'd1);
        chk({tag, "_busy"},  32'(busy),        32'd0);
    endtask

    task automatic exp_reset(input string tag);
        chk({tag, "_valid"}, 32'(dest_tvalid), 32'd0);
        chk({tag, "_last"},  32'(dest_tlast),  32'd0);
        chk({tag, "_data"},  32'(dest_tdata),  32'd0);
        chk({tag, "_busy"},  32'(busy),        32'd0);
        chk({tag, "_srdy"},  32'(src_tready),  32'd0);
    endtask

    task automatic put(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
        src_tvalid = v;
        src_tdata  = d;
        src_tkeep  = k;
        src_tlast  = l;
    endtask

    initial begin
        rst         = 1'b0;
        dest_tready = 1'b0;
        put(1'b0, 32'h0, 4'h0, 1'b0);

        // Reset held, then released between edges.
        nxt(); settle(); exp_reset("rst_hold0");
        nxt(); settle(); exp_reset("rst_hold1");
        rst = 1'b1;
        dest_tready = 1'b1;
        nxt(); settle(); exp_idle("idle0");
        nxt(); settle(); exp_idle("idle1");

        // Single full beat.
        put(1'b1, 32'h44332211, 4'hF, 1'b1);
        settle(); chk("single_srdy", 32'(src_tready), 32'd1);
        nxt(); put(1'b0, 32'h0, 4'h0, 1'b0);
        settle(); exp_lane("s0", 8'h11, 1'b0, 1'b0);
        chk("s0_busy", 32'(busy), 32'd1);
        nxt(); settle(); exp_lane("s1", 8'h22, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("s2", 8'h33, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("s3", 8'h44, 1'b1, 1'b1);
        nxt(); settle(); exp_idle("s_end");

        // Back-to-back beats with no bubble.
        put(1'b1, 32'h04030201, 4'hF, 1'b0);
        nxt(); put(1'b1, 32'h08070605, 4'hF, 1'b1);
        settle(); exp_lane("b0", 8'h01, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("b1", 8'h02, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("b2", 8'h03, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("b3", 8'h04, 1'b0, 1'b1);
        nxt(); put(1'b0, 32'h0, 4'h0, 1'b0);
        settle(); exp_lane("b4", 8'h05, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("b5", 8'h06, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("b6", 8'h07, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("b7", 8'h08, 1'b1, 1'b1);
        nxt(); settle(); exp_idle("b_end");

        // Partial beat: two lanes.
        put(1'b1, 32'hDDCCBBAA, 4'b0011, 1'b1);
        nxt(); put(1'b0, 32'h0, 4'h0, 1'b0);
        settle(); exp_lane("p0", 8'hAA, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("p1", 8'hBB, 1'b1, 1'b1);
        nxt(); settle(); exp_idle("p_end");

        // All-zero keep still emits lane 0.
        put(1'b1, 32'h000000EE, 4'b0000, 1'b1);
        nxt(); put(1'b0, 32'h0, 4'h0, 1'b0);
        settle(); exp_lane("z0", 8'hEE, 1'b1, 1'b1);
        nxt(); settle(); exp_idle("z_end");

        // Interior keep zeros are not skipped.
        put(1'b1, 32'h0C0B0A09, 4'b0100, 1'b1);
        nxt(); put(1'b0, 32'h0, 4'h0, 1'b0);
        settle(); exp_lane("k0", 8'h09, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("k1", 8'h0A, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("k2", 8'h0B, 1'b1, 1'b1);
        nxt(); settle(); exp_idle("k_end");

        // Backpressure on lane 1; junk on src must be ignored.
        put(1'b1, 32'h44332211, 4'hF, 1'b1);
        nxt(); put(1'b0, 32'h0, 4'h0, 1'b0);
        settle(); exp_lane("bp0", 8'h11, 1'b0, 1'b0);
        nxt(); dest_tready = 1'b0; put(1'b1, 32'hFFFFFFFF, 4'hF, 1'b0);
        settle(); exp_lane("bp1a", 8'h22, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("bp1b", 8'h22, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("bp1c", 8'h22, 1'b0, 1'b0);
        nxt(); dest_tready = 1'b1; put(1'b0, 32'h0, 4'h0, 1'b0);
        settle(); exp_lane("bp1d", 8'h22, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("bp2", 8'h33, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("bp3", 8'h44, 1'b1, 1'b1);
        nxt(); settle(); exp_idle("bp_end");

        // Async reset after two lanes, mid-cycle.
        put(1'b1, 32'h44332211, 4'hF, 1'b1);
        nxt(); put(1'b0, 32'h0, 4'h0, 1'b0);
        settle(); exp_lane("ar0", 8'h11, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("ar1", 8'h22, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("ar2", 8'h33, 1'b0, 1'b0);
        #1; rst = 1'b0;
        settle(); exp_reset("ar_rst");
        nxt(); rst = 1'b1;
        nxt(); settle(); exp_idle("ar_idle");
        put(1'b1, 32'hA0B0C0D0, 4'hF, 1'b1);
        nxt(); put(1'b0, 32'h0, 4'h0, 1'b0);
        settle(); exp_lane("ar_n0", 8'hD0, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("ar_n1", 8'hC0, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("ar_n2", 8'hB0, 1'b0, 1'b0);
        nxt(); settle(); exp_lane("ar_n3", 8'hA0, 1'b1, 1'b1);
        nxt(); settle(); exp_idle("ar_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
